// File: rtl/stick_sync_pkg.sv
// stick_sync_pkg: shared definitions for the stick sync/strobe generator.
//   state_t  - generator state encoding (IDLE / WAIT / RUN)
//   MODE_INT - frame requests come from the internal period counter
//   MODE_EXT - frame requests come from rising edges of the external sync
//   frame_w  - width of the frame timer and of the k*step+width arithmetic
package stick_sync_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RUN  = 2'd2
  } state_t;

  localparam logic MODE_INT = 1'b0;
  localparam logic MODE_EXT = 1'b1;

  // Wide enough for (CH_NUM-1)*step + width without overflow, assuming the
  // pulse-width field is no wider than the period/step field.
  function automatic int frame_w(input int cnt_w, input int ch_num);
    return cnt_w + $clog2(ch_num) + 1;
  endfunction

endpackage

// File: rtl/stick_sync_edge.sv
// stick_sync_edge: brings an asynchronous level into the clk domain through a
// 2-FF synchroniser, then flags its rising edge with a one-cycle pulse.
// Ports:
//   clk   - sampling clock
//   rst   - synchronous active-high reset, clears all flops
//   din   - asynchronous input level
//   pulse - high for exactly one cycle after each synchronised rising edge
module stick_sync_edge (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic pulse
);

  logic meta;
  logic sync;
  logic sync_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta   <= 1'b0;
      sync   <= 1'b0;
      sync_d <= 1'b0;
    end else begin
      meta   <= din;
      sync   <= meta;
      sync_d <= sync;
    end
  end

  // Only the settled stage is used for the edge compare; meta never leaves here.
  assign pulse = sync & ~sync_d;

endmodule

// File: rtl/stick_sync_gen.sv
// stick_sync_gen: multi-channel sync/strobe frame generator (sys_clk domain).
// A frame request comes from the internal period counter (i_mode=0) or from a
// rising edge of i_ext_sync (i_mode=1). A frame starts only while i_tx_rdy is
// high; within a frame channel k pulses for width cycles starting at k*step.
// Optional macro STICK_SYNC_INV_EN adds i_inv, a per-channel output polarity.
// Ports:
//   sys_clk, rst     - clock, synchronous active-high reset
//   i_enable         - low forces IDLE (pending and period counter cleared)
//   i_mode           - MODE_INT / MODE_EXT request source
//   i_ext_sync       - asynchronous external sync (rising edge = request)
//   i_period         - internal frame period in cycles, 0 = no requests
//   i_step, i_width  - channel offset and pulse width (width 0 acts as 1)
//   i_tx_rdy         - downstream ready
//   i_inv            - (STICK_SYNC_INV_EN only) per-channel output inversion
//   o_sync           - per-channel pulses, registered
//   o_frame_start    - one-cycle strobe on the first RUN cycle
//   o_busy           - high while in RUN
//   o_frame_cnt      - started frames, wraps
//   o_miss_cnt       - dropped requests, saturates
//   dbg_state        - current state_t encoding for observation
module stick_sync_gen
  import stick_sync_pkg::*;
#(
  parameter int CH_NUM = 4,
  parameter int CNT_W  = 24,
  parameter int WID_W  = 16,
  parameter int MISS_W = 8
) (
  input  logic              sys_clk,
  input  logic              rst,
  input  logic              i_enable,
  input  logic              i_mode,
  input  logic              i_ext_sync,
  input  logic [CNT_W-1:0]  i_period,
  input  logic [CNT_W-1:0]  i_step,
  input  logic [WID_W-1:0]  i_width,
  input  logic              i_tx_rdy,
`ifdef STICK_SYNC_INV_EN
  input  logic [CH_NUM-1:0] i_inv,
`endif
  output logic [CH_NUM-1:0] o_sync,
  output logic              o_frame_start,
  output logic              o_busy,
  output logic [15:0]       o_frame_cnt,
  output logic [MISS_W-1:0] o_miss_cnt,
  output logic [1:0]        dbg_state
);

  localparam int FW = frame_w(CNT_W, CH_NUM);

  // Handshake: a request is a one-cycle event with no back-pressure. It is
  // consumed into RUN on the next edge when i_tx_rdy is high in WAIT, held in
  // a single pending slot when i_tx_rdy is low, and otherwise dropped and
  // counted. i_tx_rdy is only looked at while in WAIT.
  state_t            state, state_n;
  logic              pending, pending_n;
  logic [CNT_W-1:0]  per_cnt, per_cnt_n;
  logic [FW-1:0]     t, t_n;
  logic [CNT_W-1:0]  step_sh, step_n;
  logic [WID_W-1:0]  wid_sh, wid_n;
  logic [WID_W-1:0]  w_eff;
  logic [FW-1:0]     last_t;
  logic              ext_pulse;
  logic              per_wrap;
  logic              req;
  logic              go_run;
  logic              miss;
  logic [CH_NUM-1:0] pulse_n;
  logic [CH_NUM-1:0] sync_n;

  stick_sync_edge u_edge (
    .clk   (sys_clk),
    .rst   (rst),
    .din   (i_ext_sync),
    .pulse (ext_pulse)
  );

  assign w_eff    = (i_width == '0) ? WID_W'(1) : i_width;
  assign last_t   = FW'(CH_NUM - 1) * FW'(step_sh) + FW'(wid_sh) - FW'(1);
  assign per_wrap = (state != IDLE) && (i_period != '0) &&
                    (per_cnt >= i_period - CNT_W'(1));
  assign req      = (state != IDLE) &&
                    ((i_mode == MODE_EXT) ? ext_pulse : per_wrap);

  always_comb begin
    per_cnt_n = per_cnt + CNT_W'(1);
    if (!i_enable || state == IDLE || i_period == '0 || per_wrap) begin
      per_cnt_n = '0;
    end
  end

  always_comb begin
    state_n   = state;
    pending_n = pending;
    t_n       = t;
    step_n    = step_sh;
    wid_n     = wid_sh;
    go_run    = 1'b0;
    miss      = 1'b0;
    if (!i_enable) begin
      // Disable wins over a coincident request: nothing is counted.
      state_n   = IDLE;
      pending_n = 1'b0;
    end else begin
      case (state)
        IDLE: state_n = WAIT;
        WAIT: begin
          miss = req & pending;
          if (i_tx_rdy && (pending || req)) begin
            go_run    = 1'b1;
            state_n   = RUN;
            pending_n = 1'b0;
            t_n       = '0;
            step_n    = i_step;
            wid_n     = w_eff;
          end else if (req) begin
            pending_n = 1'b1;
          end
        end
        RUN: begin
          miss = req;
          if (t == last_t) state_n = WAIT;
          else             t_n     = t + FW'(1);
        end
        default: state_n = IDLE;
      endcase
    end
  end

  // Outputs are registered, so pulses are decoded from next-cycle timer values.
  for (genvar k = 0; k < CH_NUM; k++) begin : g_ch
    logic [FW-1:0] off;
    assign off        = FW'(k) * FW'(step_n);
    assign pulse_n[k] = (state_n == RUN) && (t_n >= off) && (t_n < off + FW'(wid_n));
  end

`ifdef STICK_SYNC_INV_EN
  assign sync_n = pulse_n ^ i_inv;
`else
  assign sync_n = pulse_n;
`endif

  always_ff @(posedge sys_clk) begin
    if (rst) begin
      state   <= IDLE;
      pending <= 1'b0;
    end else begin
      state   <= state_n;
      pending <= pending_n;
    end
  end

  always_ff @(posedge sys_clk) begin
    if (rst) begin
      per_cnt       <= '0;
      t             <= '0;
      step_sh       <= '0;
      wid_sh        <= '0;
      o_sync        <= '0;
      o_frame_start <= 1'b0;
      o_busy        <= 1'b0;
      o_frame_cnt   <= '0;
      o_miss_cnt    <= '0;
    end else begin
      per_cnt       <= per_cnt_n;
      t             <= t_n;
      step_sh       <= step_n;
      wid_sh        <= wid_n;
      o_sync        <= sync_n;
      o_frame_start <= go_run;
      o_busy        <= (state_n == RUN);
      if (go_run) o_frame_cnt <= o_frame_cnt + 16'd1;
      if (miss && (o_miss_cnt != '1)) o_miss_cnt <= o_miss_cnt + MISS_W'(1);
    end
  end

  assign dbg_state = state;

endmodule

// File: tb/tb_stick_sync_gen.sv
// tb_stick_sync_gen: self-checking bench for stick_sync_gen (CH_NUM=4).
// Directed vector table for pulse placement, hand-written multi-cycle
// sequences, and randomized traffic checked every cycle against a
// frame-level reference model.
module tb_stick_sync_gen;
  import stick_sync_pkg::*;

  localparam int CH = 4;
  localparam int CW = 24;
  localparam int WW = 16;
  localparam int MW = 8;

  logic          sys_clk;
  logic          rst;
  logic          i_enable;
  logic          i_mode;
  logic          i_ext_sync;
  logic [CW-1:0] i_period;
  logic [CW-1:0] i_step;
  logic [WW-1:0] i_width;
  logic          i_tx_rdy;
`ifdef STICK_SYNC_INV_EN
  logic [CH-1:0] i_inv;
`endif
  logic [CH-1:0] o_sync;
  logic          o_frame_start;
  logic          o_busy;
  logic [15:0]   o_frame_cnt;
  logic [MW-1:0] o_miss_cnt;
  logic [1:0]    dbg_state;

  stick_sync_gen #(.CH_NUM(CH), .CNT_W(CW), .WID_W(WW), .MISS_W(MW)) dut (
    .sys_clk       (sys_clk),
    .rst           (rst),
    .i_enable      (i_enable),
    .i_mode        (i_mode),
    .i_ext_sync    (i_ext_sync),
    .i_period      (i_period),
    .i_step        (i_step),
    .i_width       (i_width),
    .i_tx_rdy      (i_tx_rdy),
`ifdef STICK_SYNC_INV_EN
    .i_inv         (i_inv),
`endif
    .o_sync        (o_sync),
    .o_frame_start (o_frame_start),
    .o_busy        (o_busy),
    .o_frame_cnt   (o_frame_cnt),
    .o_miss_cnt    (o_miss_cnt),
    .dbg_state     (dbg_state)
  );

  // ---------------- clock / watchdog ----------------
  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  initial begin
    #1100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard counters ----------------
  int     n_chk  = 0;
  int     n_fail = 0;
  longint cyc    = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail_timeout(input string name);
    n_chk++;
    n_fail++;
    $display("FAIL %s: timed out waiting for frame start (cycle %0d)", name, cyc);
  endtask

  // ---------------- reference model ----------------
  // Frame-level view: a frame is the window [m_t0, m_t0+m_len-1]; internal
  // requests are every i_period cycles counted from the first enabled cycle;
  // external requests are input rises seen two cycles earlier.
  bit            m_active, m_pend, m_in_frame;
  longint        m_wait0, m_t0, m_len, m_step, m_w;
  logic [2:0]    eh;
  logic [CH-1:0] e_sync;
  logic          e_fs, e_busy;
  logic [15:0]   e_fcnt;
  logic [MW-1:0] e_miss;
  state_t        e_state;

  task automatic miss_inc();
    if (e_miss != 8'hFF) e_miss = e_miss + 8'd1;
  endtask

  task automatic model_update();
    bit            req, req_ext, req_per;
    logic [CH-1:0] p;
    longint        tt;
    if (rst) begin
      m_active = 0; m_pend = 0; m_in_frame = 0;
      m_wait0 = 0; m_t0 = 0; m_len = 0; m_step = 0; m_w = 0;
      eh = 3'b000;
      e_sync = '0; e_fs = 0; e_busy = 0; e_fcnt = '0; e_miss = '0; e_state = IDLE;
    end else begin
      req_ext = eh[1] & ~eh[2];
      eh      = {eh[1:0], i_ext_sync};
      req_per = (i_period != 0) &&
                (((cyc - m_wait0) % longint'(i_period)) == longint'(i_period) - 1);
      req     = m_active && (i_mode ? req_ext : req_per);
      if (!i_enable) begin
        m_active = 0; m_pend = 0; m_in_frame = 0;
      end else if (!m_active) begin
        m_active = 1;
        m_wait0  = cyc + 1;
      end else if (m_in_frame) begin
        if (req) miss_inc();
        if (cyc == m_t0 + m_len - 1) m_in_frame = 0;
      end else begin
        if (req && m_pend) miss_inc();
        if (i_tx_rdy && (m_pend || req)) begin
          m_in_frame = 1;
          m_t0       = cyc + 1;
          m_step     = longint'(i_step);
          m_w        = (i_width == 0) ? 1 : longint'(i_width);
          m_len      = (CH - 1) * m_step + m_w;
          m_pend     = 0;
          e_fcnt     = e_fcnt + 16'd1;
        end else if (req) begin
          m_pend = 1;
        end
      end
      e_busy = m_in_frame;
      e_fs   = m_in_frame && (m_t0 == cyc + 1);
      tt     = cyc + 1 - m_t0;
      for (int k = 0; k < CH; k++)
        p[k] = m_in_frame && (tt >= k * m_step) && (tt < k * m_step + m_w);
`ifdef STICK_SYNC_INV_EN
      e_sync = p ^ i_inv;
`else
      e_sync = p;
`endif
      e_state = !m_active ? IDLE : (m_in_frame ? RUN : WAIT);
    end
  endtask

  // ---------------- driver tasks ----------------
  // Inputs are set between negedges; tick() advances one cycle and compares
  // every output with the model at the following negedge.
  task automatic tick();
    model_update();
    @(negedge sys_clk);
    cyc++;
    check("model", {dbg_state, o_sync, o_frame_start, o_busy, o_frame_cnt, o_miss_cnt},
                   {e_state, e_sync, e_fs, e_busy, e_fcnt, e_miss});
  endtask

  task automatic do_reset();
    rst = 1; i_enable = 0; i_ext_sync = 0; i_tx_rdy = 0;
    tick();
    rst = 0;
  endtask

  task automatic wait_start(input int max, output bit ok);
    ok = 0;
    for (int i = 0; i < max; i++) begin
      if (o_frame_start) begin
        ok = 1;
        break;
      end
      tick();
    end
    if (!ok) fail_timeout("wait_frame_start");
  endtask

  task automatic fire_and_wait(output bit ok);
    i_ext_sync = 1;
    tick();
    i_ext_sync = 0;
    wait_start(20, ok);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic [CW-1:0] step;
    logic [WW-1:0] width;
    int            t_probe;
    logic [CH-1:0] exp_sync;
    logic          exp_busy;
  } vec_t;

  vec_t   vecs[14];
  bit     ok;
  longint c0, s1, s2;
  int     n;

  initial begin
    vecs[0]  = '{24'd100, 16'd20, 0,   4'b0001, 1'b1};
    vecs[1]  = '{24'd100, 16'd20, 19,  4'b0001, 1'b1};
    vecs[2]  = '{24'd100, 16'd20, 20,  4'b0000, 1'b1};
    vecs[3]  = '{24'd100, 16'd20, 100, 4'b0010, 1'b1};
    vecs[4]  = '{24'd100, 16'd20, 300, 4'b1000, 1'b1};
    vecs[5]  = '{24'd100, 16'd20, 319, 4'b1000, 1'b1};
    vecs[6]  = '{24'd100, 16'd20, 320, 4'b0000, 1'b0};
    vecs[7]  = '{24'd0,   16'd0,  0,   4'b1111, 1'b1};
    vecs[8]  = '{24'd0,   16'd0,  1,   4'b0000, 1'b0};
    vecs[9]  = '{24'd5,   16'd10, 7,   4'b0011, 1'b1};
    vecs[10] = '{24'd5,   16'd10, 12,  4'b0110, 1'b1};
    vecs[11] = '{24'd5,   16'd10, 24,  4'b1000, 1'b1};
    vecs[12] = '{24'd5,   16'd10, 25,  4'b0000, 1'b0};
    vecs[13] = '{24'd1,   16'd1,  2,   4'b0100, 1'b1};

    rst = 1; i_enable = 0; i_mode = 0; i_ext_sync = 0; i_period = '0;
    i_step = '0; i_width = '0; i_tx_rdy = 0;
`ifdef STICK_SYNC_INV_EN
    i_inv = '0;
`endif
    tick();
    tick();
    check("rst_sync",        32'(o_sync),        32'd0);
    check("rst_frame_start", 32'(o_frame_start), 32'd0);
    check("rst_busy",        32'(o_busy),        32'd0);
    check("rst_frame_cnt",   32'(o_frame_cnt),   32'd0);
    check("rst_miss_cnt",    32'(o_miss_cnt),    32'd0);
    rst = 0;

    // Pulse placement from the table, one external-trigger frame per entry.
    for (int v = 0; v < 14; v++) begin
      do_reset();
      i_step = vecs[v].step; i_width = vecs[v].width;
      i_mode = MODE_EXT; i_tx_rdy = 1; i_enable = 1;
      tick();
      fire_and_wait(ok);
      if (ok) begin
        repeat (vecs[v].t_probe) tick();
        check($sformatf("vec%0d_sync", v), 32'(o_sync), 32'(vecs[v].exp_sync));
        check($sformatf("vec%0d_busy", v), 32'(o_busy), 32'(vecs[v].exp_busy));
      end
    end

    // External trigger latency: input rises at cycle 97, frame starts at 100.
    do_reset();
    i_step = 24'd10; i_width = 16'd5; i_mode = MODE_EXT; i_tx_rdy = 1; i_enable = 1;
    for (int i = 0; i < 120; i++) begin
      if (i == 97)  i_ext_sync = 1;
      if (i == 117) i_ext_sync = 0;
      tick();
      if (i + 1 == 99) check("ext_no_early_start", 32'(o_frame_start), 32'd0);
      if (i + 1 == 100) begin
        check("ext_start_at_100", 32'(o_frame_start), 32'd1);
        check("ext_frame_cnt",    32'(o_frame_cnt),   32'd1);
      end
    end

    // tx_rdy low at request; second request while pending is a miss.
    do_reset();
    i_step = 24'd10; i_width = 16'd5; i_mode = MODE_EXT; i_tx_rdy = 0; i_enable = 1;
    for (int i = 0; i < 60; i++) begin
      if (i == 0 || i == 20) i_ext_sync = 1;
      if (i == 4 || i == 24) i_ext_sync = 0;
      if (i == 52) i_tx_rdy = 1;
      tick();
      if (i + 1 == 30) check("miss_while_pending", 32'(o_miss_cnt), 32'd1);
      if (i + 1 == 52) check("no_start_before_rdy", 32'(o_frame_start), 32'd0);
      if (i + 1 == 53) check("start_after_rdy", 32'(o_frame_start), 32'd1);
    end

    // Mid-frame disable, then reset mid-frame.
    do_reset();
    i_step = 24'd100; i_width = 16'd20; i_mode = MODE_EXT; i_tx_rdy = 1; i_enable = 1;
    tick();
    fire_and_wait(ok);
    repeat (150) tick();
    check("busy_t150", 32'(o_busy), 32'd1);
    i_enable = 0;
    tick();
    check("disable_sync", 32'(o_sync), 32'd0);
    check("disable_busy", 32'(o_busy), 32'd0);
    check("disable_frame_cnt_hold", 32'(o_frame_cnt), 32'd1);
    i_enable = 1;
    tick();
    fire_and_wait(ok);
    repeat (150) tick();
    check("frame_cnt_2", 32'(o_frame_cnt), 32'd2);
    rst = 1;
    tick();
    check("midrst_sync",      32'(o_sync),        32'd0);
    check("midrst_start",     32'(o_frame_start), 32'd0);
    check("midrst_busy",      32'(o_busy),        32'd0);
    check("midrst_frame_cnt", 32'(o_frame_cnt),   32'd0);
    check("midrst_miss_cnt",  32'(o_miss_cnt),    32'd0);
    rst = 0;

    // Internal period 30000, frame 320 cycles.
    do_reset();
    i_period = 24'd30000; i_step = 24'd100; i_width = 16'd20;
    i_mode = MODE_INT; i_tx_rdy = 1; i_enable = 1;
    c0 = cyc;
    wait_start(30100, ok);
    s1 = cyc;
    check("per_first_start", 32'(s1 - c0), 32'd30001);
    n = 0;
    while (o_busy && n < 400) begin
      if (n == 19)  check("per_ch0_t19",  32'(o_sync[0]), 32'd1);
      if (n == 20)  check("per_ch0_t20",  32'(o_sync[0]), 32'd0);
      if (n == 300) check("per_ch3_t300", 32'(o_sync[3]), 32'd1);
      if (n == 319) check("per_ch3_t319", 32'(o_sync[3]), 32'd1);
      n++;
      tick();
    end
    check("per_busy_len", 32'(n), 32'd320);
    wait_start(30100, ok);
    s2 = cyc;
    check("per_interval", 32'(s2 - s1), 32'd30000);

    // Period 200 vs frame 320: every other request dropped; then saturation.
    do_reset();
    i_period = 24'd200; i_step = 24'd100; i_width = 16'd20;
    i_mode = MODE_INT; i_tx_rdy = 1; i_enable = 1;
    repeat (1650) tick();
    check("alt_miss_cnt",  32'(o_miss_cnt),  32'd4);
    check("alt_frame_cnt", 32'(o_frame_cnt), 32'd4);
    i_enable = 0;
    tick();
    i_period = 24'd10;
    i_enable = 1;
    repeat (3500) tick();
    check("miss_saturated", 32'(o_miss_cnt), 32'd255);

    // Randomized traffic against the model.
    for (int s = 0; s < 8; s++) begin
      i_enable = 0;
      tick();
      i_period = CW'($urandom_range(0, 40));
      for (int c = 0; c < 400; c++) begin
        rst        = ($urandom_range(0, 299) == 0);
        i_enable   = ($urandom_range(0, 99) != 0);
        i_mode     = 1'($urandom_range(0, 1));
        i_ext_sync = ($urandom_range(0, 5) == 0);
        i_tx_rdy   = ($urandom_range(0, 3) != 0);
        i_step     = CW'($urandom_range(0, 6));
        i_width    = WW'($urandom_range(0, 5));
`ifdef STICK_SYNC_INV_EN
        i_inv      = CH'($urandom_range(0, 15));
`endif
        tick();
      end
    end
    rst = 0;

`ifdef STICK_SYNC_INV_EN
    i_inv = 4'b0101;
    i_enable = 0;
    rst = 1;
    tick();
    check("inv_reset_sync", 32'(o_sync), 32'd0);
    rst = 0;
    tick();
    check("inv_idle_sync", 32'(o_sync), 32'h5);
    tick();
    check("inv_idle_sync_hold", 32'(o_sync), 32'h5);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
